// File: rtl/motor_pkg.sv
// Shared constants and state encoding for the per-wheel motor command stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package motor_pkg;

  // Conditioning stage states. ST_DEAD is only reachable when the
  // dead-time feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DEAD  = 3'd4
  } motor_state_t;

  // Defaults for a 16 MHz core clock: 1 kHz pwm, 100 us ramp tick,
  // 1% duty per tick, 1 ms dead time before a reversal.
  localparam int unsigned DEF_PERIOD   = 16000;
  localparam int unsigned DEF_STEP_DIV = 1600;
  localparam int unsigned DEF_STEP     = 160;
  localparam int unsigned DEF_DEADTIME = 16000;

  // Common speed set-points, as duty values against DEF_PERIOD.
  localparam int unsigned SPEED25  = 4000;
  localparam int unsigned SPEED50  = 8000;
  localparam int unsigned SPEED75  = 12000;
  localparam int unsigned SPEED100 = 16000;

endpackage

// File: rtl/ramp_tick.sv
// Restartable divider: one-cycle tick every STEP_DIV clocks.
// Latency: tick asserts in the cycle the count steps to STEP_DIV-1; STEP_DIV-1 cycles after restart.
// Backpressure: none; free-running, restart is a synchronous clear.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   restart     synchronous clear; count is 0 in the following cycle
//   tick        high for the one cycle in which the count advances to STEP_DIV-1
module ramp_tick
  import motor_pkg::*;
#(
  parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = '0;
    if (!restart && (r_cnt != L_LAST)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Tick is decoded from the next count so that whatever the tick updates
  // lands in the same cycle the count shows STEP_DIV-1.
  assign tick = !restart && (w_cnt_nxt == L_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/motor_ramp.sv
// Per-wheel command conditioning: slews pwm duty toward target, drains/flips on reversal.
// Latency: command -> en/busy/cmd_ready next cycle; first duty change STEP_DIV cycles after acceptance.
// Backpressure: cmd_ready high only in IDLE/HOLD; stop masks acceptance while high.
//
// Config macro MOTOR_RAMP_DEADTIME_EN: when defined, a DEAD state holds zero
// duty for DEADTIME cycles before the direction flips (and the DEADTIME
// parameter exists); otherwise dir flips the cycle after duty reaches 0.
//
// Ports:
//   WF_CLK, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_duty/cmd_dir/cmd_en  target duty (clamped to PERIOD), direction, enable
//   stop                     level emergency stop, overrides everything
//   duty, drive              duty to pwm, high when duty != 0
//   dir, en                  motor pins
//   busy, at_target          ramp/reversal in progress, output equals target
module motor_ramp
  import motor_pkg::*;
#(
  parameter int unsigned DUTY_W   = 16,
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV,
`ifdef MOTOR_RAMP_DEADTIME_EN
  parameter int unsigned DEADTIME = DEF_DEADTIME,
`endif
  parameter int unsigned STEP     = DEF_STEP
) (
  input  logic              WF_CLK,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              cmd_en,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              drive,
  output logic              dir,
  output logic              en,
  output logic              busy,
  output logic              at_target
);

  localparam logic [DUTY_W-1:0] L_PERIOD = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] L_STEP   = DUTY_W'(STEP);

  motor_state_t      r_state, w_state_nxt;
  logic [DUTY_W-1:0] r_duty, w_duty_nxt;
  logic [DUTY_W-1:0] r_target, w_target_nxt;
  logic [DUTY_W-1:0] w_cmd_tgt, w_step_tgt, w_stepped;
  logic [DUTY_W:0]   w_up_sum, w_dn_lim;
  logic              r_dir, w_dir_nxt;
  logic              r_tgt_dir, w_tgt_dir_nxt;
  logic              r_en, w_en_nxt;
  logic              r_settled, r_busy, w_settled_nxt;
  logic              w_accept, w_restart, w_tick;

`ifdef MOTOR_RAMP_DEADTIME_EN
  localparam int unsigned DEAD_W = $clog2(DEADTIME + 1);
  localparam logic [DEAD_W-1:0] L_DEAD_LAST = DEAD_W'(DEADTIME - 1);
  logic [DEAD_W-1:0] r_dead_cnt, w_dead_cnt_nxt;
`endif

  ramp_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk     (WF_CLK),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // stop is checked here rather than folded into cmd_ready so that a command
  // presented during stop is never taken, even though IDLE shows ready.
  assign w_accept  = cmd_valid && r_settled && !stop;
  assign w_cmd_tgt = (cmd_duty > L_PERIOD) ? L_PERIOD : cmd_duty;

  // One saturating step toward the current goal (0 while draining).
  // Sums are one bit wider so a near-full-scale duty cannot wrap.
  assign w_step_tgt = (r_state == ST_DRAIN) ? '0 : r_target;
  assign w_up_sum   = {1'b0, r_duty} + {1'b0, L_STEP};
  assign w_dn_lim   = {1'b0, w_step_tgt} + {1'b0, L_STEP};

  always_comb begin
    w_stepped = w_step_tgt;
    if (r_duty < w_step_tgt) begin
      if (w_up_sum < {1'b0, w_step_tgt}) w_stepped = w_up_sum[DUTY_W-1:0];
    end else if ({1'b0, r_duty} > w_dn_lim) begin
      w_stepped = r_duty - L_STEP;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_duty_nxt    = r_duty;
    w_target_nxt  = r_target;
    w_dir_nxt     = r_dir;
    w_tgt_dir_nxt = r_tgt_dir;
    w_en_nxt      = r_en;
    w_restart     = 1'b0;
`ifdef MOTOR_RAMP_DEADTIME_EN
    w_dead_cnt_nxt = '0;
`endif
    if (stop) begin
      w_state_nxt  = ST_IDLE;
      w_duty_nxt   = '0;
      w_target_nxt = '0;
      w_en_nxt     = 1'b0;
    end else if (w_accept) begin
      w_restart = 1'b1;
      if (!cmd_en) begin
        w_state_nxt  = ST_IDLE;
        w_duty_nxt   = '0;
        w_target_nxt = '0;
        w_en_nxt     = 1'b0;
      end else begin
        w_en_nxt      = 1'b1;
        w_target_nxt  = w_cmd_tgt;
        w_tgt_dir_nxt = cmd_dir;
        if (cmd_dir == r_dir) begin
          w_state_nxt = ST_RAMP;
        end else if (r_duty != '0) begin
          w_state_nxt = ST_DRAIN;
        end else begin
`ifdef MOTOR_RAMP_DEADTIME_EN
          w_state_nxt = ST_DEAD;
`else
          // Already at zero: DRAIN flips dir on the following cycle.
          w_state_nxt = ST_DRAIN;
`endif
        end
      end
    end else begin
      case (r_state)
        ST_RAMP: begin
          if (w_tick) begin
            w_duty_nxt = w_stepped;
            if (w_stepped == r_target) w_state_nxt = ST_HOLD;
          end else if (r_duty == r_target) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (r_duty == '0) begin
`ifdef MOTOR_RAMP_DEADTIME_EN
            w_state_nxt = ST_DEAD;
`else
            w_dir_nxt   = r_tgt_dir;
            w_restart   = 1'b1;
            w_state_nxt = (r_target == '0) ? ST_HOLD : ST_RAMP;
`endif
          end else if (w_tick) begin
            w_duty_nxt = w_stepped;
`ifdef MOTOR_RAMP_DEADTIME_EN
            if (w_stepped == '0) w_state_nxt = ST_DEAD;
`endif
          end
        end
`ifdef MOTOR_RAMP_DEADTIME_EN
        ST_DEAD: begin
          if (r_dead_cnt == L_DEAD_LAST) begin
            w_dir_nxt   = r_tgt_dir;
            w_restart   = 1'b1;
            w_state_nxt = (r_target == '0) ? ST_HOLD : ST_RAMP;
          end else begin
            w_dead_cnt_nxt = r_dead_cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign w_settled_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD);

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_duty    <= '0;
      r_target  <= '0;
      r_dir     <= 1'b0;
      r_tgt_dir <= 1'b0;
      r_en      <= 1'b0;
      r_settled <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_target  <= w_target_nxt;
      r_dir     <= w_dir_nxt;
      r_tgt_dir <= w_tgt_dir_nxt;
      r_en      <= w_en_nxt;
      r_settled <= w_settled_nxt;
      r_busy    <= !w_settled_nxt;
    end
  end

`ifdef MOTOR_RAMP_DEADTIME_EN
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_dead_cnt <= '0;
    end else begin
      r_dead_cnt <= w_dead_cnt_nxt;
    end
  end
`endif

  assign duty      = r_duty;
  assign drive     = (r_duty != '0);
  assign dir       = r_dir;
  assign en        = r_en;
  assign cmd_ready = r_settled;
  assign at_target = r_settled;
  assign busy      = r_busy;

endmodule
